// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
//
// Instruction-fetch sequencer. Owns the program counter, runs a req/ack
// handshake with instruction memory (any number of wait cycles), and drives
// the IF/ID pipeline register's data, load enable and flush inputs.
// A one-entry buffer catches a word that returns while decode is stalled.
// After a redirect, a response that is still outstanding is discarded.
//
// Ports:
//   i_Clock        clock, rising edge
//   i_Reset_n      asynchronous active-low reset
//   o_IMemReq      fetch request, held until ack
//   o_IMemAddr     fetch address (always r_PC)
//   i_IMemAck      one-cycle response strobe, only honoured while requesting
//   i_IMemData     instruction word returned with the ack
//   i_Stall        decode hazard: IF/ID must hold
//   i_Redirect     branch/jump taken (one-cycle pulse)
//   i_RedirectPC   redirect target, low two bits ignored
//   o_FetchNextPC  PC+4 of the instruction presented to IF/ID
//   o_FetchInstr   instruction presented to IF/ID
//   o_FetchValid   o_FetchInstr/o_FetchNextPC are valid
//   o_IFIDEnable   IF/ID load enable
//   o_IFIDFlush    IF/ID valid clear, dominates enable
//   o_BubbleCount  saturating count of cycles without a valid IF/ID load
// -----------------------------------------------------------------------------
module fetch_controller #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          PERF_WIDTH = 16
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_n,
  output logic                  o_IMemReq,
  output logic [31:0]           o_IMemAddr,
  input  logic                  i_IMemAck,
  input  logic [31:0]           i_IMemData,
  input  logic                  i_Stall,
  input  logic                  i_Redirect,
  input  logic [31:0]           i_RedirectPC,
  output logic [31:0]           o_FetchNextPC,
  output logic [31:0]           o_FetchInstr,
  output logic                  o_FetchValid,
  output logic                  o_IFIDEnable,
  output logic                  o_IFIDFlush,
  output logic [PERF_WIDTH-1:0] o_BubbleCount
);

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  state_t                r_State;
  state_t                w_NextState;
  logic [31:0]           r_PC;
  logic [31:0]           w_NextPC;
  logic [31:0]           r_Pending;
  logic [31:0]           w_NextPending;
  logic [31:0]           r_BufInstr;
  logic [31:0]           r_BufNextPC;
  logic                  w_BufLoad;
  logic [PERF_WIDTH-1:0] r_BubbleCount;
  logic                  w_Bubble;

  logic [31:0]           w_PCPlus4;
  logic [31:0]           w_RedirTarget;
  logic                  w_Req;
  logic                  w_Valid;
  logic                  w_Enable;
  logic                  w_Flush;
  logic [31:0]           w_Instr;
  logic [31:0]           w_NextPCOut;

  function automatic logic [PERF_WIDTH-1:0] sat_inc(input logic [PERF_WIDTH-1:0] v);
    return (&v) ? v : v + PERF_WIDTH'(1);
  endfunction

  // Natural 32-bit wrap gives 0xFFFF_FFFC + 4 = 0.
  assign w_PCPlus4     = r_PC + 32'd4;
  assign w_RedirTarget = i_RedirectPC & ~32'd3;

  always_comb begin
    w_NextState   = r_State;
    w_NextPC      = r_PC;
    w_NextPending = r_Pending;
    w_BufLoad     = 1'b0;
    w_Req         = 1'b0;
    w_Valid       = 1'b0;
    w_Enable      = 1'b0;
    w_Flush       = 1'b0;
    w_Instr       = r_BufInstr;
    w_NextPCOut   = r_BufNextPC;

    case (r_State)
      ST_BOOT: begin
        // Redirects are ignored here; always move on to the first fetch.
        w_Flush     = 1'b1;
        w_NextState = ST_REQ;
      end

      ST_REQ: begin
        w_Req       = 1'b1;
        w_Instr     = i_IMemData;
        w_NextPCOut = w_PCPlus4;
        if (i_Redirect) begin
          w_Flush = 1'b1;
          if (i_IMemAck) begin
            w_NextPC = w_RedirTarget;
          end else begin
            // Keep the address stable until the old request completes.
            w_NextPending = w_RedirTarget;
            w_NextState   = ST_DISCARD;
          end
        end else if (i_IMemAck) begin
          w_Valid  = 1'b1;
          w_NextPC = w_PCPlus4;
          if (i_Stall) begin
            w_BufLoad   = 1'b1;
            w_NextState = ST_HOLD;
          end else begin
            w_Enable = 1'b1;
          end
        end else begin
          w_Enable = !i_Stall;
        end
      end

      ST_HOLD: begin
        if (i_Redirect) begin
          w_Flush     = 1'b1;
          w_NextPC    = w_RedirTarget;
          w_NextState = ST_REQ;
        end else begin
          w_Valid  = 1'b1;
          w_Enable = !i_Stall;
          if (!i_Stall) begin
            w_NextState = ST_REQ;
          end
        end
      end

      ST_DISCARD: begin
        w_Req = 1'b1;
        if (i_Redirect) begin
          w_Flush       = 1'b1;
          w_NextPending = w_RedirTarget;
          if (i_IMemAck) begin
            w_NextPC    = w_RedirTarget;
            w_NextState = ST_REQ;
          end
        end else begin
          w_Enable = !i_Stall;
          if (i_IMemAck) begin
            w_NextPC    = r_Pending;
            w_NextState = ST_REQ;
          end
        end
      end

      default: begin
        w_NextState = ST_BOOT;
      end
    endcase
  end

  assign w_Bubble = (r_State != ST_BOOT) && !(w_Valid && w_Enable);

  // Control state: asynchronously reset.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_State       <= ST_BOOT;
      r_PC          <= RESET_PC;
      r_BubbleCount <= '0;
    end else begin
      r_State <= w_NextState;
      r_PC    <= w_NextPC;
      if (w_Bubble) begin
        r_BubbleCount <= sat_inc(r_BubbleCount);
      end
    end
  end

  // Data holding registers: only meaningful once qualified by state.
  always_ff @(posedge i_Clock) begin
    r_Pending <= w_NextPending;
    if (w_BufLoad) begin
      r_BufInstr  <= i_IMemData;
      r_BufNextPC <= w_PCPlus4;
    end
  end

  assign o_IMemReq     = w_Req;
  assign o_IMemAddr    = r_PC;
  assign o_FetchValid  = w_Valid;
  assign o_FetchInstr  = w_Instr;
  assign o_FetchNextPC = w_NextPCOut;
  assign o_IFIDEnable  = w_Enable;
  assign o_IFIDFlush   = w_Flush;
  assign o_BubbleCount = r_BubbleCount;

endmodule

// File: tb/tb_fetch_controller.sv
// -----------------------------------------------------------------------------
// tb_fetch_controller
//
// Directed bench for fetch_controller. dut0 uses RESET_PC=0 and walks through
// same-cycle acks, wait states, a stalled ack, redirects into DISCARD, and a
// mid-request reset. dut1 uses RESET_PC=0xFFFF_FFFC with a 2-bit bubble
// counter, a permanently acking memory and a permanently stalled decode, to
// cover PC wrap and counter saturation.
// -----------------------------------------------------------------------------
module tb_fetch_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ack;
  logic [31:0] dat;
  logic        stall;
  logic        redir;
  logic [31:0] rpc;

  logic        req;
  logic [31:0] addr;
  logic [31:0] npc;
  logic [31:0] instr;
  logic        valid;
  logic        en;
  logic        flush;
  logic [15:0] bub;

  logic        ack1;
  logic [31:0] dat1;
  logic        stall1;
  logic        redir1;
  logic [31:0] rpc1;
  logic        req1;
  logic [31:0] addr1;
  logic [31:0] npc1;
  logic [31:0] instr1;
  logic        valid1;
  logic        en1;
  logic        flush1;
  logic [1:0]  bub1;

  int checks = 0;
  int errors = 0;

  fetch_controller #(.RESET_PC(32'h0000_0000), .PERF_WIDTH(16)) dut0 (
    .i_Clock      (clk),
    .i_Reset_n    (rst_n),
    .o_IMemReq    (req),
    .o_IMemAddr   (addr),
    .i_IMemAck    (ack),
    .i_IMemData   (dat),
    .i_Stall      (stall),
    .i_Redirect   (redir),
    .i_RedirectPC (rpc),
    .o_FetchNextPC(npc),
    .o_FetchInstr (instr),
    .o_FetchValid (valid),
    .o_IFIDEnable (en),
    .o_IFIDFlush  (flush),
    .o_BubbleCount(bub)
  );

  fetch_controller #(.RESET_PC(32'hFFFF_FFFC), .PERF_WIDTH(2)) dut1 (
    .i_Clock      (clk),
    .i_Reset_n    (rst_n),
    .o_IMemReq    (req1),
    .o_IMemAddr   (addr1),
    .i_IMemAck    (ack1),
    .i_IMemData   (dat1),
    .i_Stall      (stall1),
    .i_Redirect   (redir1),
    .i_RedirectPC (rpc1),
    .o_FetchNextPC(npc1),
    .o_FetchInstr (instr1),
    .o_FetchValid (valid1),
    .o_IFIDEnable (en1),
    .o_IFIDFlush  (flush1),
    .o_BubbleCount(bub1)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; outputs are checked 1ns later.
  task automatic drive(input logic a, input logic [31:0] d, input logic s,
                       input logic r, input logic [31:0] p);
    @(negedge clk);
    ack   = a;
    dat   = d;
    stall = s;
    redir = r;
    rpc   = p;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    ack    = 1'b0;
    dat    = 32'h0;
    stall  = 1'b0;
    redir  = 1'b0;
    rpc    = 32'h0;
    ack1   = 1'b1;
    dat1   = 32'h0BAD_F00D;
    stall1 = 1'b1;
    redir1 = 1'b0;
    rpc1   = 32'h0;

    // Reset state
    @(negedge clk);
    #1;
    chk1 ("rst_req",    req,   1'b0);
    chk1 ("rst_valid",  valid, 1'b0);
    chk1 ("rst_en",     en,    1'b0);
    chk1 ("rst_flush",  flush, 1'b1);
    chk32("rst_bub",    32'(bub), 32'd0);
    chk32("rst_addr",   addr,  32'h0);
    chk32("rst_addr1",  addr1, 32'hFFFF_FFFC);

    // Release: still BOOT until the next rising edge
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk1 ("boot_req",   req,   1'b0);
    chk1 ("boot_flush", flush, 1'b1);

    // Same-cycle acks at 0 and 4
    drive(1'b1, 32'hA000_0000, 1'b0, 1'b0, 32'h0);
    chk1 ("a_req",   req,   1'b1);
    chk32("a_addr",  addr,  32'h0);
    chk1 ("a_valid", valid, 1'b1);
    chk32("a_instr", instr, 32'hA000_0000);
    chk32("a_npc",   npc,   32'h4);
    chk1 ("a_en",    en,    1'b1);
    chk1 ("a_flush", flush, 1'b0);
    chk32("a_bub",   32'(bub), 32'd0);
    chk1 ("a_req1",  req1,  1'b1);
    chk32("a_addr1", addr1, 32'hFFFF_FFFC);

    drive(1'b1, 32'hA000_0004, 1'b0, 1'b0, 32'h0);
    chk32("b_addr",   addr,  32'h4);
    chk1 ("b_valid",  valid, 1'b1);
    chk32("b_npc",    npc,   32'h8);
    chk1 ("b_req1",   req1,  1'b0);
    chk1 ("b_valid1", valid1, 1'b1);
    chk32("b_instr1", instr1, 32'h0BAD_F00D);
    chk32("b_npc1",   npc1,  32'h0);
    chk32("b_addr1",  addr1, 32'h0);
    chk32("b_bub1",   32'(bub1), 32'd1);

    // Three-cycle latency at 0x8
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk32("w1_addr",  addr,  32'h8);
    chk1 ("w1_valid", valid, 1'b0);
    chk1 ("w1_en",    en,    1'b1);
    chk32("w1_bub",   32'(bub), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk32("w2_addr",  addr,  32'h8);
    chk1 ("w2_valid", valid, 1'b0);
    chk1 ("w2_en",    en,    1'b1);
    drive(1'b1, 32'hA000_0008, 1'b0, 1'b0, 32'h0);
    chk32("w3_addr",  addr,  32'h8);
    chk1 ("w3_valid", valid, 1'b1);
    chk32("w3_npc",   npc,   32'hC);
    chk32("w3_bub",   32'(bub), 32'd2);

    drive(1'b1, 32'hA000_000C, 1'b0, 1'b0, 32'h0);
    chk32("c_addr",  addr, 32'hC);
    chk32("c_bub",   32'(bub), 32'd2);
    chk32("c_bub1",  32'(bub1), 32'd3);

    // Ack at 0x10 under stall, then three stalled HOLD cycles
    drive(1'b1, 32'hA000_0010, 1'b1, 1'b0, 32'h0);
    chk32("s_addr", addr, 32'h10);
    chk1 ("s_en",   en,   1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
      chk1 ("hold_req",   req,   1'b0);
      chk1 ("hold_valid", valid, 1'b1);
      chk32("hold_instr", instr, 32'hA000_0010);
      chk32("hold_npc",   npc,   32'h14);
      chk1 ("hold_en",    en,    1'b0);
    end
    drive(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    chk1 ("rel_req",   req,   1'b0);
    chk1 ("rel_valid", valid, 1'b1);
    chk32("rel_instr", instr, 32'hA000_0010);
    chk1 ("rel_en",    en,    1'b1);
    chk32("rel_bub",   32'(bub), 32'd6);

    drive(1'b1, 32'hA000_0014, 1'b0, 1'b0, 32'h0);
    chk32("n14_addr", addr, 32'h14);
    chk1 ("n14_req",  req,  1'b1);
    chk32("n14_npc",  npc,  32'h18);
    drive(1'b1, 32'hA000_0018, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 32'hA000_001C, 1'b0, 1'b0, 32'h0);
    chk32("n1c_addr", addr, 32'h1C);

    // Redirect to 0x103 while 0x20 is outstanding
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk32("r20_addr", addr, 32'h20);
    chk1 ("r20_en",   en,   1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);
    chk1 ("rd_flush", flush, 1'b1);
    chk1 ("rd_en",    en,    1'b0);
    chk32("rd_addr",  addr,  32'h20);
    chk1 ("rd_valid", valid, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk1 ("dc_req",   req,   1'b1);
    chk32("dc_addr",  addr,  32'h20);
    chk1 ("dc_valid", valid, 1'b0);
    chk1 ("dc_flush", flush, 1'b0);
    chk1 ("dc_en",    en,    1'b1);
    drive(1'b1, 32'hBAD0_0020, 1'b0, 1'b0, 32'h0);
    chk32("dca_addr",  addr,  32'h20);
    chk1 ("dca_valid", valid, 1'b0);
    chk32("dca_bub",   32'(bub), 32'd9);
    drive(1'b1, 32'hA000_0100, 1'b0, 1'b0, 32'h0);
    chk32("t100_addr",  addr,  32'h100);
    chk1 ("t100_valid", valid, 1'b1);
    chk32("t100_instr", instr, 32'hA000_0100);
    chk32("t100_npc",   npc,   32'h104);
    chk32("t100_bub",   32'(bub), 32'd10);

    // Two redirects during DISCARD, second one together with a stall
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200);
    chk1 ("r2_flush", flush, 1'b1);
    chk32("r2_addr",  addr,  32'h104);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0300);
    chk1 ("r3_flush", flush, 1'b1);
    chk1 ("r3_en",    en,    1'b0);
    chk32("r3_addr",  addr,  32'h104);
    chk1 ("r3_req",   req,   1'b1);
    drive(1'b1, 32'hBAD0_0104, 1'b0, 1'b0, 32'h0);
    chk1 ("r3a_valid", valid, 1'b0);
    chk1 ("r3a_en",    en,    1'b1);
    chk32("r3a_addr",  addr,  32'h104);
    drive(1'b1, 32'hA000_0300, 1'b0, 1'b0, 32'h0);
    chk32("t300_addr",  addr,  32'h300);
    chk1 ("t300_valid", valid, 1'b1);
    chk32("t300_npc",   npc,   32'h304);
    chk32("t300_bub",   32'(bub), 32'd13);

    // Redirect together with ack in REQ: data dropped, go straight to target
    drive(1'b1, 32'hA000_0304, 1'b0, 1'b1, 32'h0000_0400);
    chk1 ("ra_valid", valid, 1'b0);
    chk1 ("ra_flush", flush, 1'b1);
    chk1 ("ra_en",    en,    1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk32("t400_addr",  addr,  32'h400);
    chk1 ("t400_req",   req,   1'b1);
    chk1 ("t400_valid", valid, 1'b0);
    chk32("t400_bub",   32'(bub), 32'd14);
    chk32("t400_bub1",  32'(bub1), 32'd3);

    // Reset while the request at 0x400 is outstanding
    rst_n = 1'b0;
    #1;
    chk1 ("mr_req",   req,   1'b0);
    chk1 ("mr_flush", flush, 1'b1);
    chk32("mr_addr",  addr,  32'h0);
    chk32("mr_bub",   32'(bub), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk1 ("mr_boot_req", req, 1'b0);
    drive(1'b1, 32'hA000_0000, 1'b0, 1'b0, 32'h0);
    chk1 ("mr_req2",   req,   1'b1);
    chk32("mr_addr2",  addr,  32'h0);
    chk1 ("mr_valid2", valid, 1'b1);
    chk32("mr_npc2",   npc,   32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequences the instruction-fetch stage and drives the IF/ID pipeline register's data, enable and flush inputs. It owns the program counter and runs a req/ack handshake with instruction memory that allows a variable number of wait cycles. It holds a one-entry buffer for a fetched word that arrives while decode is stalled, and it discards stale responses after a branch redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
PERF_WIDTH, 16, width of saturating fetch-bubble counter

Ports:
i_Clock  in  1  clock, rising edge
i_Reset_n  in  1  asynchronous active-low reset
o_IMemReq  out  1  fetch request, held until ack
o_IMemAddr  out  32  fetch address, stable while o_IMemReq=1
i_IMemAck  in  1  one-cycle pulse, i_IMemData valid; sampled only while o_IMemReq=1
i_IMemData  in  32  instruction word
i_Stall  in  1  decode hazard: IF/ID must hold
i_Redirect  in  1  branch/jump taken (one-cycle pulse)
i_RedirectPC  in  32  redirect target; bits [1:0] ignored (treated as 00)
o_FetchNextPC  out  32  PC+4 of instruction presented to IF/ID
o_FetchInstr  out  32  instruction presented to IF/ID
o_FetchValid  out  1  o_FetchInstr/o_FetchNextPC valid
o_IFIDEnable  out  1  IF/ID load enable (combinational)
o_IFIDFlush  out  1  IF/ID valid clear (combinational); has priority over enable
o_BubbleCount  out  PERF_WIDTH  saturating count of cycles where IF/ID does not load a valid instruction

Behaviour:
- Clock and reset: one clock, i_Clock. Reset is asynchronous, active-low, on i_Reset_n. Reset values:
  - state=BOOT, r_PC=RESET_PC
  - o_IMemReq=0, o_FetchValid=0, o_IFIDEnable=0, buffer empty, o_BubbleCount=0
  - o_IFIDFlush=1 while in BOOT
- o_IMemAddr=r_PC at all times.
- Reset mid-request abandons the request. Instruction memory shares the same reset.
- States and transitions:
  - BOOT:
    - o_IMemReq=0, o_IFIDFlush=1.
    - Always goes to REQ on the next clock, even if i_Redirect is high; i_Redirect is ignored in BOOT.
  - REQ: o_IMemReq=1.
    - Ack, no redirect, no stall:
      - o_FetchValid=1 with i_IMemData and r_PC+4.
      - o_IFIDEnable=1, r_PC<=r_PC+4, stay in REQ. Back-to-back fetches give 1 instruction/cycle when ack is same-cycle.
    - Ack, no redirect, stall:
      - Capture i_IMemData and r_PC+4 into the buffer.
      - r_PC<=r_PC+4, go to HOLD, o_IFIDEnable=0.
    - No ack, no redirect:
      - o_FetchValid=0, o_IFIDEnable=!i_Stall. An unstalled decode takes a bubble.
    - Redirect with ack in the same cycle:
      - Drop the data, r_PC<=i_RedirectPC&~3, stay in REQ.
    - Redirect without ack:
      - r_Pending<=i_RedirectPC&~3, go to DISCARD. r_PC is unchanged so the address stays stable.
  - HOLD: o_IMemReq=0, o_FetchValid=1 from the buffer, o_IFIDEnable=!i_Stall.
    - !i_Stall: buffer consumed, go to REQ.
    - Redirect: drop the buffer, r_PC<=i_RedirectPC&~3, go to REQ.
  - DISCARD: o_IMemReq=1 at the old r_PC, o_FetchValid=0, o_IFIDEnable=!i_Stall.
    - Ack: drop the data, r_PC<=r_Pending, go to REQ.
    - New redirect: overwrites r_Pending; latest wins.
    - Ack and redirect in the same cycle: r_PC<=new target.
- Redirect handling in every state except BOOT:
  - o_IFIDFlush=1 and o_IFIDEnable=0 in the cycle of i_Redirect.
  - Redirect beats stall.
  - First valid instruction from the target appears no earlier than the cycle after the redirect.
- Arithmetic: r_PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000). o_FetchNextPC wraps the same way.
- o_BubbleCount: increments in every cycle where !(o_FetchValid && o_IFIDEnable) and the state is not BOOT. Saturates at all ones.

Test Plan:
- Reset release, RESET_PC=0, memory acks in the same cycle as each req -> addresses 0,4,8,..., o_FetchValid=1 every cycle from the first REQ cycle; o_FetchNextPC=4,8,12.
- Memory with 3-cycle ack latency -> o_IMemAddr held at 0x8 for 3 cycles; 2 bubble cycles with o_IFIDEnable=1 and o_FetchValid=0; o_BubbleCount increments by 2.
- Ack at 0x10 while i_Stall=1 for 4 cycles:
  - State HOLD with o_IMemReq=0.
  - o_FetchInstr stays equal to the captured word.
  - Enable rises with the stall drop.
  - Next request goes to 0x14.
- Redirect to 0x103 while a request at 0x20 is outstanding:
  - Flush pulses, addr stays 0x20 until ack, that ack's data never appears valid.
  - Next request goes to 0x100.
- Two redirects (0x200, then 0x300) during DISCARD, then ack -> next request goes to 0x300. Redirect and stall in the same cycle -> flush=1, enable=0.
- RESET_PC=32'hFFFF_FFFC -> o_FetchNextPC=0 and the next address is 0. Assert i_Reset_n=0 mid-request -> o_IMemReq drops immediately and the block restarts at BOOT.
